// File: rtl/screen_ctrl_if.sv
// Signal bundle between the SkyHop screen sequencer and its surroundings:
// frame/key/fall events in, overlay enables and BCD scores out.
interface screen_ctrl_if;
  logic        frame_tick;
  logic        key_left;
  logic        key_right;
  logic        player_fell;
  logic        start_en;
  logic        play_en;
  logic        over_en;
  logic        game_rst;
  logic [15:0] score;
  logic [15:0] best_score;

  modport master (
    output frame_tick, key_left, key_right, player_fell,
    input  start_en, play_en, over_en, game_rst, score, best_score
  );

  modport slave (
    input  frame_tick, key_left, key_right, player_fell,
    output start_en, play_en, over_en, game_rst, score, best_score
  );
endinterface

// File: rtl/screen_ctrl.sv
// SkyHop screen sequencer: START/PLAY/OVER phases switched only on frame
// boundaries, plus BCD current and best hop scores.
module screen_ctrl #(
  parameter int HOLD_FRAMES = 60
) (
  input  logic          clk,
  input  logic          rst,
  screen_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  state_t              state, state_nxt;
  state_t              pend_target, target_nxt;
  logic                pending, pending_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [15:0]         score, score_nxt;
  logic [15:0]         best_score, best_nxt;
  logic                game_rst, game_rst_nxt;
  logic                start_en, play_en, over_en;
  logic                key;
  logic                apply;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign key   = bus.key_left | bus.key_right;
  // A request only takes effect on a tick seen while it is already pending.
  assign apply = bus.frame_tick & pending;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt    = state;
    target_nxt   = pend_target;
    pending_nxt  = pending;
    score_nxt    = score;
    best_nxt     = best_score;
    hold_nxt     = hold_cnt;
    game_rst_nxt = 1'b0;

    if (apply) begin
      state_nxt   = pend_target;
      pending_nxt = 1'b0;
      if (pend_target == ST_PLAY) begin
        score_nxt    = 16'h0000;
        game_rst_nxt = 1'b1;
      end else if (pend_target == ST_OVER) begin
        hold_nxt = HOLD_W'(HOLD_FRAMES);
        if (score > best_score) best_nxt = score;
      end
    end else begin
      case (state)
        ST_START: begin
          if (key && !pending) begin
            pending_nxt = 1'b1;
            target_nxt  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Once a fall is pending the run is over: no further increments.
          if (!pending) begin
            if (bus.player_fell) begin
              pending_nxt = 1'b1;
              target_nxt  = ST_OVER;
            end else if (key && score != 16'h9999) begin
              score_nxt = bcd_inc(score);
            end
          end
        end
        ST_OVER: begin
          if (bus.frame_tick && hold_cnt != '0) begin
            hold_nxt = hold_cnt - 1'b1;
          end else if (key && hold_cnt == '0 && !pending) begin
            pending_nxt = 1'b1;
            target_nxt  = ST_START;
          end
        end
        default: state_nxt = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_START;
      pend_target <= ST_START;
      pending     <= 1'b0;
      score       <= 16'h0000;
      best_score  <= 16'h0000;
      hold_cnt    <= '0;
      game_rst    <= 1'b0;
      start_en    <= 1'b1;
      play_en     <= 1'b0;
      over_en     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state       <= state_nxt;
      pend_target <= target_nxt;
      pending     <= pending_nxt;
      score       <= score_nxt;
      best_score  <= best_nxt;
      hold_cnt    <= hold_nxt;
      game_rst    <= game_rst_nxt;
      start_en    <= (state_nxt == ST_START);
      play_en     <= (state_nxt == ST_PLAY);
      over_en     <= (state_nxt == ST_OVER);
    end
  end

  assign bus.start_en   = start_en;
  assign bus.play_en    = play_en;
  assign bus.over_en    = over_en;
  assign bus.game_rst   = game_rst;
  assign bus.score      = score;
  assign bus.best_score = best_score;

endmodule

// File: tb/tb_screen_ctrl.sv
// Self-checking bench for screen_ctrl: vector table, directed corner cases
// and random traffic against an integer-level reference model.
module tb_screen_ctrl;

  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  screen_ctrl_if bus ();

  screen_ctrl #(.HOLD_FRAMES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=start 1=play 2=over, scores as plain integers.
  int m_phase, m_target, m_score, m_best, m_hold;
  bit m_pend, m_grst;

  typedef struct {
    int          reps;
    bit          rst, tick, kl, kr, fell;
    bit          e_start, e_play, e_over, e_grst;
    logic [15:0] e_score, e_best;
    string       name;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {bus.start_en, bus.play_en, bus.over_en, bus.game_rst, bus.score, bus.best_score};
  endfunction

  function automatic logic [35:0] model_vec();
    return {m_phase == 0, m_phase == 1, m_phase == 2, m_grst, to_bcd(m_score), to_bcd(m_best)};
  endfunction

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got en(s/p/o)=%b game_rst=%b score=%h best=%h, want en=%b game_rst=%b score=%h best=%h",
               name, got[35:33], got[32], got[31:16], got[15:0],
               want[35:33], want[32], want[31:16], want[15:0]);
    end
  endtask

  task automatic model_update(input bit r, input bit t, input bit l, input bit rr, input bit f);
    bit k;
    k = l | rr;
    if (r) begin
      m_phase = 0; m_target = 0; m_pend = 0;
      m_score = 0; m_best = 0; m_hold = 0; m_grst = 0;
    end else begin
      m_grst = 0;
      if (t && m_pend) begin
        m_phase = m_target;
        m_pend  = 0;
        if (m_target == 1) begin
          m_score = 0;
          m_grst  = 1;
        end else if (m_target == 2) begin
          m_hold = HOLD;
          if (m_score > m_best) m_best = m_score;
        end
      end else if (m_phase == 0) begin
        if (k && !m_pend) begin m_pend = 1; m_target = 1; end
      end else if (m_phase == 1) begin
        if (!m_pend && f) begin
          m_pend = 1; m_target = 2;
        end else if (!m_pend && k) begin
          m_score = (m_score < 9999) ? m_score + 1 : 9999;
        end
      end else begin
        if (t && m_hold > 0) m_hold--;
        else if (k && m_hold == 0 && !m_pend) begin m_pend = 1; m_target = 0; end
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic step(input bit r, input bit t, input bit l, input bit rr, input bit f);
    rst             = r;
    bus.frame_tick  = t;
    bus.key_left    = l;
    bus.key_right   = rr;
    bus.player_fell = f;
    @(posedge clk);
    model_update(r, t, l, rr, f);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic expect_out(input string name, input bit s, input bit p, input bit o,
                            input bit g, input logic [15:0] sc, input logic [15:0] bs);
    check(name, dut_vec(), {s, p, o, g, sc, bs});
  endtask

  initial begin
    bit r, t, l, rr, f;

    vecs[0]  = '{1,    1,0,0,0,0, 1,0,0,0, 16'h0000, 16'h0000, "reset_state"};
    vecs[1]  = '{1,    0,1,0,1,0, 1,0,0,0, 16'h0000, 16'h0000, "tick_collision"};
    vecs[2]  = '{99,   0,0,0,0,0, 1,0,0,0, 16'h0000, 16'h0000, "wait_frame"};
    vecs[3]  = '{1,    0,1,0,0,0, 0,1,0,1, 16'h0000, 16'h0000, "enter_play"};
    vecs[4]  = '{1,    0,0,0,0,0, 0,1,0,0, 16'h0000, 16'h0000, "game_rst_one_cycle"};
    vecs[5]  = '{9,    0,0,1,0,0, 0,1,0,0, 16'h0009, 16'h0000, "nine_keys"};
    vecs[6]  = '{1,    0,0,1,1,0, 0,1,0,0, 16'h0010, 16'h0000, "both_keys_carry"};
    vecs[7]  = '{90,   0,0,0,1,0, 0,1,0,0, 16'h0100, 16'h0000, "ninety_keys"};
    vecs[8]  = '{9898, 0,0,1,0,0, 0,1,0,0, 16'h9998, 16'h0000, "reach_9998"};
    vecs[9]  = '{3,    0,0,0,1,0, 0,1,0,0, 16'h9999, 16'h0000, "saturate_9999"};
    vecs[10] = '{1,    0,0,0,0,1, 0,1,0,0, 16'h9999, 16'h0000, "fall_pending"};
    vecs[11] = '{1,    0,1,0,0,0, 0,0,1,0, 16'h9999, 16'h9999, "enter_over_best"};
    vecs[12] = '{3,    0,1,0,0,0, 0,0,1,0, 16'h9999, 16'h9999, "hold_ticks"};
    vecs[13] = '{1,    0,0,1,0,0, 0,0,1,0, 16'h9999, 16'h9999, "restart_key"};
    vecs[14] = '{1,    0,1,0,0,0, 1,0,0,0, 16'h9999, 16'h9999, "back_to_start"};

    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < vecs[i].reps; k++)
        step(vecs[i].rst, vecs[i].tick, vecs[i].kl, vecs[i].kr, vecs[i].fell);
      check(vecs[i].name, dut_vec(),
            {vecs[i].e_start, vecs[i].e_play, vecs[i].e_over, vecs[i].e_grst,
             vecs[i].e_score, vecs[i].e_best});
    end

    // Fall beats a simultaneous key; hold period ignores keys on ticks 1..3.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    expect_out("best_seeded_7", 0, 0, 1, 0, 16'h0007, 16'h0007);
    for (int i = 0; i < HOLD; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    expect_out("replay_cleared", 0, 1, 0, 1, 16'h0000, 16'h0007);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    expect_out("fall_wins", 0, 1, 0, 0, 16'h0005, 16'h0007);
    step(0, 0, 0, 1, 0);
    expect_out("no_inc_after_fall", 0, 1, 0, 0, 16'h0005, 16'h0007);
    step(0, 1, 0, 0, 0);
    expect_out("over_best_kept", 0, 0, 1, 0, 16'h0005, 16'h0007);
    for (int i = 0; i < HOLD; i++) begin
      step(0, 1, 1, 0, 0);
      expect_out("hold_key_ignored", 0, 0, 1, 0, 16'h0005, 16'h0007);
    end
    step(0, 1, 0, 0, 0);
    expect_out("no_latched_key", 0, 0, 1, 0, 16'h0005, 16'h0007);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    expect_out("restart_to_start", 1, 0, 0, 0, 16'h0005, 16'h0007);

    // Reset in the middle of a pending request drops it.
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    expect_out("reset_drops_req", 1, 0, 0, 0, 16'h0000, 16'h0000);
    step(0, 0, 0, 0, 0);
    expect_out("no_game_rst", 1, 0, 0, 0, 16'h0000, 16'h0000);

    // Random traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 999) == 0);
      t  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 39) == 0);
      step(r, t, l, rr, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
